// File: rtl/siso_tx_ctrl_pkg.sv
// Shared types and constants for the two-requester serial transmit controller.
package siso_pkg;
  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;
endpackage

// File: rtl/siso_tx_ctrl_if.sv
// Handshake and serial-output bundle between the producers/sink and siso_tx_ctrl.
interface siso_tx_ctrl_if
  import siso_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]  in_valid;
  logic [NREQ-1:0]  in_ready;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             frame_end;
  logic             owner;
  logic             busy;

  modport master (
    output in_valid, in_data0, in_data1,
    input  in_ready, sout, sout_valid, frame_start, frame_end, owner, busy
  );

  modport slave (
    input  in_valid, in_data0, in_data1,
    output in_ready, sout, sout_valid, frame_start, frame_end, owner, busy
  );
endinterface

// File: rtl/siso_tx_ctrl_arb.sv
// Two-way round-robin arbiter; the pointer moves past the winner on each advance.
module rr_arb2
  import siso_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] gnt
);
  // ptr = 1 means requester 1 wins a tie
  logic ptr;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     ptr <= 1'b0;
    else if (adv) ptr <= gnt[0];
  end
endmodule

// File: rtl/siso_tx_ctrl.sv
// Round-robin two-requester loader feeding a right-shifting SISO register,
// LSB first, with framing strobes and a programmable idle gap per frame.
module siso_tx_ctrl
  import siso_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
)(
  input  logic           clk,
  input  logic           rst,
  siso_tx_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             own;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  acc;
  logic             last;
  logic             shifting;
  logic             gap_done;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.in_valid),
    .adv (|acc),
    .gnt (gnt)
  );

  // Grants are only visible in IDLE and are forced low throughout reset
  assign bus.in_ready = (rst && state == IDLE) ? gnt : '0;
  assign acc          = bus.in_valid & bus.in_ready;
  assign last         = (cnt == CW'(WIDTH - 1));
  assign shifting     = (state == SHIFT);

  generate
    if (GAP > 0) begin : g_gap
      localparam int GCW = $clog2(GAP + 1);
      logic [GCW-1:0] gcnt;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         gcnt <= '0;
        else if (state == siso_pkg::GAP)  gcnt <= gcnt + 1'b1;
        else                              gcnt <= '0;
      end

      assign gap_done = (gcnt == GCW'(GAP - 1));
    end else begin : g_nogap
      assign gap_done = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      own   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|acc) begin
            sreg  <= acc[1] ? bus.in_data1 : bus.in_data0;
            own   <= acc[1];
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= sreg >> 1;
          cnt  <= cnt + 1'b1;
          if (last) state <= (GAP > 0) ? siso_pkg::GAP : IDLE;
        end
        siso_pkg::GAP: begin
          if (gap_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sout        = shifting & sreg[0];
  assign bus.sout_valid  = shifting;
  assign bus.frame_start = shifting && (cnt == '0);
  assign bus.frame_end   = shifting && last;
  assign bus.owner       = own;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_siso_tx_ctrl.sv
// Bench for siso_tx_ctrl: vector table plus hand sequences, serial frames
// checked against a queue of expected {owner, word} records.
module tb_siso_tx_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  siso_tx_ctrl_if #(.WIDTH(4)) ifa ();
  siso_tx_ctrl_if #(.WIDTH(4)) ifb ();

  siso_tx_ctrl #(.WIDTH(4), .GAP(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  siso_tx_ctrl #(.WIDTH(4), .GAP(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct {
    logic       own;
    logic [3:0] data;
  } exp_t;

  typedef struct {
    logic [1:0] v;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] rdy;
    logic       own;
    logic [3:0] data;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[8];
  int   npass = 0;
  int   ntot  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s act=%0h exp=%0h at cyc %0d", nm, act, exp, cyc);
  endtask

  // Frame monitor on dut_a: strobes, owner stability and reassembled word
  int         idx = 0;
  logic [3:0] mbits;
  logic       mown;
  always @(negedge clk) begin
    if (!rst) begin
      idx = 0;
    end else if (ifa.sout_valid) begin
      chk("frame_start", ifa.frame_start, idx == 0);
      chk("frame_end", ifa.frame_end, idx == 3);
      if (idx == 0) mown = ifa.owner;
      else chk("owner_stable", ifa.owner, mown);
      mbits[idx] = ifa.sout;
      if (idx == 3) begin
        chk("sb_nonempty", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("frame_owner", mown, e.own);
          chk("frame_data", mbits, e.data);
        end
        idx = 0;
      end else begin
        idx++;
      end
    end else begin
      chk("strobes_quiet", {ifa.frame_start, ifa.frame_end, ifa.sout}, 0);
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk); #1;
      if (!ifa.busy) begin ok = 1; break; end
    end
    chk("idle_timeout", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sfb;
    logic [4:0] bsv, bso, brd;
    int         lastc;
    bit         found;

    vt[0] = '{2'b11, 4'hA, 4'h5, 2'b10, 1'b1, 4'h5};
    vt[1] = '{2'b11, 4'h3, 4'hC, 2'b01, 1'b0, 4'h3};
    vt[2] = '{2'b01, 4'h6, 4'h0, 2'b01, 1'b0, 4'h6};
    vt[3] = '{2'b10, 4'h0, 4'h9, 2'b10, 1'b1, 4'h9};
    vt[4] = '{2'b10, 4'h0, 4'hE, 2'b10, 1'b1, 4'hE};
    vt[5] = '{2'b11, 4'hF, 4'h1, 2'b01, 1'b0, 4'hF};
    vt[6] = '{2'b11, 4'h8, 4'h7, 2'b10, 1'b1, 4'h7};
    vt[7] = '{2'b01, 4'h2, 4'h0, 2'b01, 1'b0, 4'h2};

    rst = 1'b1;
    ifa.in_valid = 2'b11; ifa.in_data0 = '0; ifa.in_data1 = '0;
    ifb.in_valid = 2'b00; ifb.in_data0 = '0; ifb.in_data1 = '0;
    #2 rst = 1'b0;

    // Reset state with both requesters valid
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", ifa.in_ready, 0);
    chk("rst_sout_valid", ifa.sout_valid, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_owner", ifa.owner, 0);
    chk("rst_sout", ifa.sout, 0);
    chk("rst_b_in_ready", ifb.in_ready, 0);
    @(negedge clk); #1 rst = 1'b1;
    #1 chk("rel_in_ready", ifa.in_ready, 2'b01);
    #1 ifa.in_valid = 2'b00;

    // Single frame 1011 from requester 0
    @(negedge clk); #1;
    ifa.in_data0 = 4'b1011; ifa.in_valid = 2'b01;
    #1 chk("sf_rdy", ifa.in_ready, 2'b01);
    sbq.push_back('{1'b0, 4'b1011});
    @(posedge clk); #1 ifa.in_valid = 2'b00;
    sfb = 4'b1011;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("sf_sout", ifa.sout, sfb[c]);
      chk("sf_busy", ifa.busy, 1);
    end
    @(negedge clk); #1;
    chk("gap_busy", ifa.busy, 1);
    chk("gap_sout_valid", ifa.sout_valid, 0);
    chk("gap_sout", ifa.sout, 0);
    @(negedge clk); #1;
    chk("post_gap_idle", ifa.busy, 0);

    // Vector table, one frame per entry from IDLE
    for (int i = 0; i < 8; i++) begin
      ifa.in_valid = vt[i].v; ifa.in_data0 = vt[i].d0; ifa.in_data1 = vt[i].d1;
      #1 chk("vec_rdy", ifa.in_ready, vt[i].rdy);
      sbq.push_back('{vt[i].own, vt[i].data});
      @(posedge clk); #1 ifa.in_valid = 2'b00;
      wait_idle();
    end

    // Abort a requester-1 frame after two bits
    ifa.in_valid = 2'b10; ifa.in_data1 = 4'h9;
    #1 chk("abort_rdy", ifa.in_ready, 2'b10);
    @(posedge clk); #1 ifa.in_valid = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    chk("abort_pre_busy", ifa.busy, 1);
    #1 rst = 1'b0;
    ifa.in_valid = 2'b11; ifa.in_data0 = 4'hA; ifa.in_data1 = 4'h5;
    #1;
    chk("abort_sout_valid", ifa.sout_valid, 0);
    chk("abort_busy", ifa.busy, 0);
    chk("abort_sout", ifa.sout, 0);
    chk("abort_fstart", ifa.frame_start, 0);
    chk("abort_owner", ifa.owner, 0);
    chk("abort_in_ready", ifa.in_ready, 0);
    @(negedge clk); #1 rst = 1'b1;
    #1;

    // Continuous contention: owners 0,1,0,1 with a 6-cycle period
    lastc = 0;
    for (int n = 0; n < 4; n++) begin
      found = 0;
      for (int t = 0; t < 20; t++) begin
        if (ifa.in_ready != 2'b00) begin found = 1; break; end
        @(negedge clk); #2;
      end
      chk("cont_found", found, 1);
      chk("cont_rdy", ifa.in_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
      sbq.push_back('{n[0], (n % 2 == 0) ? 4'hA : 4'h5});
      if (n > 0) chk("cont_period", cyc - lastc, 6);
      lastc = cyc;
      @(posedge clk); #1;
    end
    ifa.in_valid = 2'b00;
    wait_idle();

    // Requester 1 held off during a requester-0 frame; data changes before accept
    ifa.in_valid = 2'b01; ifa.in_data0 = 4'h6; ifa.in_data1 = 4'h3;
    #1 chk("hold_rdy0", ifa.in_ready, 2'b01);
    sbq.push_back('{1'b0, 4'h6});
    @(posedge clk); #1 ifa.in_valid = 2'b10;
    found = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk); #1;
      if (!ifa.busy) begin found = 1; break; end
      chk("hold_rdy_low", ifa.in_ready, 0);
      if (t == 1) ifa.in_data1 = 4'hC;
    end
    chk("hold_found", found, 1);
    chk("hold_grant", ifa.in_ready, 2'b10);
    sbq.push_back('{1'b1, 4'hC});
    @(posedge clk); #1 ifa.in_valid = 2'b00;
    wait_idle();

    // GAP=0 build: continuous 0110, period 5
    bsv = 5'b11110; bso = 5'b01100; brd = 5'b00001;
    ifb.in_data0 = 4'b0110; ifb.in_valid = 2'b01;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk("g0_sout_valid", ifb.sout_valid, bsv[c % 5]);
      chk("g0_sout", ifb.sout, bso[c % 5]);
      chk("g0_rdy", ifb.in_ready, brd[c % 5]);
      @(negedge clk); #1;
    end
    ifb.in_valid = 2'b00;
    wait_idle();

    chk("sb_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/siso_tx_ctrl.md
# siso_tx_ctrl

Two-requester serial transmit controller built around a right-shifting SISO register. Each requester offers a parallel word with a valid/ready handshake. The block grants one requester round-robin, loads the word, and shifts it out LSB first on a single serial line with framing strobes, then inserts a programmable idle gap. It sits between parallel producers and any single-bit serial sink in the shift-register datapath.

## Interface
Parameters:
- WIDTH, 4, bits per frame; legal range ≥2
- GAP, 1, idle cycles after each frame; legal range ≥0

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  2  per-requester word valid
- in_data0  in  WIDTH  word from requester 0
- in_data1  in  WIDTH  word from requester 1
- in_ready  out  2  per-requester accept, at most one bit high (one-hot or zero)
- sout  out  1  serial data, LSB first
- sout_valid  out  1  high while sout carries a frame bit
- frame_start  out  1  high on the first bit of a frame
- frame_end  out  1  high on the last bit of a frame
- owner  out  1  requester id of the frame in flight
- busy  out  1  high in SHIFT or GAP

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready[i] is high only when i is the arbiter's pick among the asserted in_valid bits; it is combinational from state, in_valid and the priority pointer.
  - A transfer occurs on the edge where in_valid[i] and in_ready[i] are both high. On that edge: shift register ← in_data_i, owner ← i, bit counter ← 0, state → SHIFT, priority pointer → the other requester.
- Arbitration:
  - Round-robin.
  - When only one requester is valid, it is granted regardless of the pointer.
  - After reset the pointer favours requester 0.
- SHIFT:
  - sout = sreg[0]; sout_valid = 1.
  - Each edge: sreg shifts right by 1 (zero fill) and the counter increments.
  - frame_start = (cnt == 0); frame_end = (cnt == WIDTH-1).
  - On the edge with cnt == WIDTH-1: go to GAP, with the gap counter ← 0, if GAP > 0; otherwise go to IDLE.
- GAP:
  - sout_valid = 0, sout = 0.
  - Stays for GAP cycles, then goes to IDLE.
- Handshake rules:
  - in_ready is 0 in SHIFT and GAP.
  - Requesters hold in_valid and data stable until accepted.
  - The controller never captures an unaccepted word.
  - Data changes before acceptance are legal; the value present at the accept edge is the value sent.
- Width rules:
  - Bit counter is $clog2(WIDTH) bits.
  - Gap counter is $clog2(GAP+1) bits and is omitted when GAP = 0.
- Reset, async assert:
  - Takes effect immediately, mid-frame included; the frame is aborted.
  - State → IDLE; sreg, counters, owner → 0; pointer → requester 0.
  - All outputs 0: sout, sout_valid, frame_start, frame_end, owner, busy, in_ready. in_ready stays 0 while rst is low.

## Timing
- Accept at edge k: first bit on sout during the cycle after edge k; last bit after edge k+WIDTH-1.
- Frame period under continuous demand is 1 + WIDTH + GAP cycles (the IDLE accept cycle is mandatory).
- sout, sout_valid, strobes and busy derive only from registered state, with no path from in_valid. in_ready is the only combinational output.
- Simultaneous requests in IDLE: exactly one in_ready bit is high, chosen by the pointer.
- Reset deassertion: the first accept can occur on the first rising edge after rst goes high.

## Structure
- Shared package siso_pkg:
  - state typedef enum {IDLE, SHIFT, GAP}
  - NREQ = 2 constant
- One sub-module: rr_arb2, the two-way round-robin arbiter.
  - Inputs: req[1:0], an advance strobe, clk, rst.
  - Outputs: one-hot gnt[1:0].
  - Owns the priority pointer.
- The shift register, counters and FSM are inline in siso_tx_ctrl.

## Test plan
All scenarios use WIDTH=4, GAP=1 unless noted.
- Reset: rst=0 with in_valid=2'b11 → in_ready=0, sout_valid=0, busy=0, owner=0. Release → in_ready=2'b01 at the next evaluation.
- Single frame: in_data0=4'b1011, in_valid=2'b01 → accept, then sout=1,1,0,1 over 4 cycles. frame_start on cycle 1, frame_end on cycle 4, owner=0. Then 1 gap cycle with busy=1 and sout_valid=0, then IDLE.
- Contention: both valid continuously, in_data0=4'hA, in_data1=4'h5 → owners alternate 0,1,0,1; bits 0,1,0,1 then 1,0,1,0; frame period 6 cycles.
- Reset mid-frame: assert rst after 2 bits of a req1 frame → outputs 0 immediately, with no waiting for an edge. After release with both valid, req0 is granted and the full 4-bit word is sent.
- GAP=0 build: continuous req0 with 4'b0110 → sout_valid pattern 0,1,1,1,1 repeating; period 5 cycles.
- Hold while busy: raise in_valid[1] during a req0 frame with in_data1 changed from 4'h3 to 4'hC mid-frame → in_ready[1] stays 0 until IDLE; the frame sends 0,0,1,1 (the 4'hC value at the accept edge).
